// File: rtl/isram_arbiter.sv
// ---------------------------------------------------------------------------
// isram_arbiter
//   Shares the single-port instruction SRAM between the fetch unit and the
//   load/store unit. Load/store normally wins. A starvation counter forces
//   one fetch slot after STARVE_MAX consecutive load/store grants that were
//   issued while fetch was waiting. Read ownership is registered so each
//   requester sees its rvalid/rdata one cycle after its grant. The last
//   fetch word is held so fe_rdata stays stable while load/store owns the
//   SRAM.
//
// Ports
//   clk, cpurst_n                 clock, asynchronous active-low reset
//   fe_req/fe_adr                 fetch read request (doubleword address)
//   fe_gnt/fe_rvalid/fe_rdata     fetch grant, read return, data (or held word)
//   ls_req/ls_we/ls_adr           load/store request, write flag, address
//   ls_wdata/ls_wbe               load/store write data and byte enables
//   ls_gnt/ls_rvalid/ls_rdata     load/store grant, read return, data
//   sram_cs/we/adr/wdata/wbe      SRAM command, issued in the grant cycle
//   sram_rdata                    SRAM read data, one cycle after a read
//   lr_isram_cs/lr_isram_cs_ff    load/store grant and its registered copy
// ---------------------------------------------------------------------------
module isram_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int DW         = 64
) (
    input  logic              clk,
    input  logic              cpurst_n,
    input  logic              fe_req,
    input  logic [28:0]       fe_adr,
    output logic              fe_gnt,
    output logic              fe_rvalid,
    output logic [DW-1:0]     fe_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [28:0]       ls_adr,
    input  logic [DW-1:0]     ls_wdata,
    input  logic [DW/8-1:0]   ls_wbe,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DW-1:0]     ls_rdata,
    output logic              sram_cs,
    output logic              sram_we,
    output logic [28:0]       sram_adr,
    output logic [DW-1:0]     sram_wdata,
    output logic [DW/8-1:0]   sram_wbe,
    input  logic [DW-1:0]     sram_rdata,
    output logic              lr_isram_cs,
    output logic              lr_isram_cs_ff
);

    typedef enum logic {ARB = 1'b0, FORCE = 1'b1} state_t;

    state_t        state, state_next;
    logic [3:0]    starve_cnt, starve_cnt_next;
    logic          fe_vld_p1;
    logic          ls_vld_p1;
    logic          cs_p1;
    logic [DW-1:0] hold_p1;

    // State register and read-return stage
    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            state      <= ARB;
            starve_cnt <= 4'd0;
            fe_vld_p1  <= 1'b0;
            ls_vld_p1  <= 1'b0;
            cs_p1      <= 1'b0;
            hold_p1    <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_cnt_next;
            fe_vld_p1  <= fe_gnt;
            ls_vld_p1  <= ls_gnt & ~ls_we;
            cs_p1      <= ls_gnt;
            // The fresh fetch word is captured while it is on sram_rdata
            if (fe_vld_p1)
                hold_p1 <= sram_rdata;
        end
    end

    // Next-state: only load/store grants that leave fetch waiting count
    // toward starvation; everything else clears the counter.
    always_comb begin
        state_next      = ARB;
        starve_cnt_next = 4'd0;
        if (state == ARB && ls_gnt && fe_req) begin
            starve_cnt_next = starve_cnt + 4'd1;
            if (starve_cnt_next == 4'(STARVE_MAX))
                state_next = FORCE;
        end
    end

    // Grants: FORCE only overrides load/store while fetch is actually
    // requesting; otherwise it arbitrates exactly like ARB.
    always_comb begin
        fe_gnt = 1'b0;
        ls_gnt = 1'b0;
        if (state == FORCE && fe_req)
            fe_gnt = 1'b1;
        else if (ls_req)
            ls_gnt = 1'b1;
        else if (fe_req)
            fe_gnt = 1'b1;
    end

    // SRAM command mux; with no grant the address follows fetch
    assign sram_cs    = fe_gnt | ls_gnt;
    assign sram_we    = ls_gnt & ls_we;
    assign sram_adr   = ls_gnt ? ls_adr : fe_adr;
    assign sram_wdata = ls_gnt ? ls_wdata : '0;
    assign sram_wbe   = ls_gnt ? ls_wbe : '0;

    assign ls_rvalid      = ls_vld_p1;
    assign ls_rdata       = sram_rdata;
    assign fe_rvalid      = fe_vld_p1;
    assign fe_rdata       = fe_vld_p1 ? sram_rdata : hold_p1;
    assign lr_isram_cs    = ls_gnt;
    assign lr_isram_cs_ff = cs_p1;

endmodule

// File: tb/tb_isram_arbiter.sv
module tb_isram_arbiter;

    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            cpurst_n;
    logic            fe_req;
    logic [28:0]     fe_adr;
    logic            fe_gnt, fe_rvalid;
    logic [DW-1:0]   fe_rdata;
    logic            ls_req, ls_we;
    logic [28:0]     ls_adr;
    logic [DW-1:0]   ls_wdata;
    logic [DW/8-1:0] ls_wbe;
    logic            ls_gnt, ls_rvalid;
    logic [DW-1:0]   ls_rdata;
    logic            sram_cs, sram_we;
    logic [28:0]     sram_adr;
    logic [DW-1:0]   sram_wdata;
    logic [DW/8-1:0] sram_wbe;
    logic [DW-1:0]   sram_rdata;
    logic            lr_isram_cs, lr_isram_cs_ff;

    int n_tests = 0;
    int n_fail  = 0;

    isram_arbiter #(.STARVE_MAX(4), .DW(DW)) dut (
        .clk(clk), .cpurst_n(cpurst_n),
        .fe_req(fe_req), .fe_adr(fe_adr), .fe_gnt(fe_gnt),
        .fe_rvalid(fe_rvalid), .fe_rdata(fe_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_adr(ls_adr),
        .ls_wdata(ls_wdata), .ls_wbe(ls_wbe), .ls_gnt(ls_gnt),
        .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_adr(sram_adr),
        .sram_wdata(sram_wdata), .sram_wbe(sram_wbe), .sram_rdata(sram_rdata),
        .lr_isram_cs(lr_isram_cs), .lr_isram_cs_ff(lr_isram_cs_ff)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected grant pattern for ls+fe held together from a clear counter
    logic [5:0] exp_ls = 6'b101111;   // bit i = cycle i
    logic [5:0] exp_fe = 6'b010000;

    initial begin
        cpurst_n   = 1'b0;
        fe_req     = 1'b0;
        fe_adr     = '0;
        ls_req     = 1'b0;
        ls_we      = 1'b0;
        ls_adr     = '0;
        ls_wdata   = '0;
        ls_wbe     = '0;
        sram_rdata = 64'hFFFF_0000_DEAD_BEEF;

        // Reset state
        #1;
        chk("rst_fe_rvalid", fe_rvalid, 0);
        chk("rst_ls_rvalid", ls_rvalid, 0);
        chk("rst_cs_ff", lr_isram_cs_ff, 0);
        chk("rst_fe_rdata", fe_rdata, 0);
        chk("rst_sram_cs", sram_cs, 0);
        step();
        step();
        cpurst_n = 1'b1;
        step();

        // Single fetch read
        fe_req = 1'b1;
        fe_adr = 29'h100;
        #1;
        chk("fe_gnt", fe_gnt, 1);
        chk("fe_ls_gnt", ls_gnt, 0);
        chk("fe_sram_cs", sram_cs, 1);
        chk("fe_sram_adr", sram_adr, 29'h100);
        chk("fe_sram_we", sram_we, 0);
        chk("fe_sram_wbe", sram_wbe, 0);
        step();
        fe_req     = 1'b0;
        sram_rdata = 64'hA5A5;
        ls_req     = 1'b1;
        ls_adr     = 29'h20;
        #1;
        chk("fe_rvalid", fe_rvalid, 1);
        chk("fe_rdata", fe_rdata, 64'hA5A5);
        chk("fe_no_ls_rvalid", ls_rvalid, 0);

        // Three load/store reads: fetch data must hold
        for (int i = 0; i < 3; i++) begin
            step();
            sram_rdata = 64'h1234_0000 + 64'(i);
            #1;
            chk("hold_ls_gnt", ls_gnt, 1);
            chk("hold_fe_rvalid", fe_rvalid, 0);
            chk("hold_fe_rdata", fe_rdata, 64'hA5A5);
            chk("hold_ls_rvalid", ls_rvalid, 1);
            chk("hold_ls_rdata", ls_rdata, 64'h1234_0000 + 64'(i));
        end
        ls_req = 1'b0;
        step();

        // Starvation: both held six cycles
        ls_req = 1'b1;
        fe_req = 1'b1;
        fe_adr = 29'h108;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("starve_ls_gnt", ls_gnt, exp_ls[i]);
            chk("starve_fe_gnt", fe_gnt, exp_fe[i]);
            if (i == 0) chk("both_lr_isram_cs", lr_isram_cs, 1);
            step();
            if (i == 0) begin
                chk("both_ls_rvalid", ls_rvalid, 1);
                chk("both_cs_ff", lr_isram_cs_ff, 1);
            end
            if (i == 4) begin
                chk("forced_fe_rvalid", fe_rvalid, 1);
                chk("forced_no_ls_rvalid", ls_rvalid, 0);
                chk("forced_cs_ff", lr_isram_cs_ff, 0);
            end
        end
        ls_req = 1'b0;
        fe_req = 1'b0;
        step();

        // FORCE reached but fetch drops its request: load/store still served,
        // then arbitration restarts from a clear counter.
        ls_req = 1'b1;
        fe_req = 1'b1;
        for (int i = 0; i < 4; i++) step();
        fe_req = 1'b0;
        #1;
        chk("force_nofe_ls_gnt", ls_gnt, 1);
        chk("force_nofe_fe_gnt", fe_gnt, 0);
        step();
        fe_req = 1'b1;
        #1;
        chk("after_force_ls_gnt", ls_gnt, 1);
        chk("after_force_fe_gnt", fe_gnt, 0);
        ls_req = 1'b0;
        fe_req = 1'b0;
        step();

        // Load/store write
        ls_req   = 1'b1;
        ls_we    = 1'b1;
        ls_adr   = 29'h40;
        ls_wdata = 64'h1122_3344;
        ls_wbe   = 8'h0F;
        #1;
        chk("wr_sram_cs", sram_cs, 1);
        chk("wr_sram_we", sram_we, 1);
        chk("wr_sram_wbe", sram_wbe, 8'h0F);
        chk("wr_sram_wdata", sram_wdata, 64'h1122_3344);
        chk("wr_sram_adr", sram_adr, 29'h40);
        step();
        ls_req = 1'b0;
        ls_we  = 1'b0;
        ls_wbe = '0;
        #1;
        chk("wr_no_ls_rvalid", ls_rvalid, 0);
        chk("wr_cs_ff", lr_isram_cs_ff, 1);
        chk("idle_sram_cs", sram_cs, 0);
        step();

        // Reset one cycle after a fetch grant
        fe_req = 1'b1;
        fe_adr = 29'h200;
        sram_rdata = 64'h7777;
        step();
        fe_req   = 1'b0;
        cpurst_n = 1'b0;
        #1;
        chk("rstmid_fe_rvalid", fe_rvalid, 0);
        chk("rstmid_fe_rdata", fe_rdata, 0);
        step();
        cpurst_n = 1'b1;
        step();
        chk("rstmid_no_rvalid", fe_rvalid, 0);

        // Reset with counter at 3 must clear it: four ls grants before fe
        ls_req = 1'b1;
        fe_req = 1'b1;
        for (int i = 0; i < 3; i++) step();
        cpurst_n = 1'b0;
        #1;
        cpurst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("rstcnt_ls_gnt", ls_gnt, exp_ls[i]);
            chk("rstcnt_fe_gnt", fe_gnt, exp_fe[i]);
            step();
        end
        ls_req = 1'b0;
        fe_req = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
